// File: rtl/spi_slave_ctrl.sv
// SPI slave, CPOL/CPHA selectable; rx_data/rx_valid one clk after the last sample edge, tx via a valid/ready holding register.
// No rx backpressure (rx_data is overwritten). Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting; default is MSB-first.
module spi_slave_ctrl #(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             sck,
   input  logic             ssel_,
   input  logic             mosi,
   output logic             miso,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic             led
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_dly_q, sck_dly_d;
   logic                   ssel_dly_q, ssel_dly_d;
   logic [SYNC_STAGES:0]   warm_q, warm_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]       rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0]       rx_data_q, rx_data_d;
   logic [WIDTH-1:0]       tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0]       hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   underrun_q, underrun_d;
   logic                   pend_q, pend_d;
   logic                   miso_bit_q, miso_bit_d;

   logic             sck_s, ssel_s, mosi_s;
   logic             rise, fall, lead, trail, active;
   logic             sample_ev, shift_ev, last_bit, ssel_fall, accept;
   logic [WIDTH-1:0] rx_next, load_word;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return w[0];
   endfunction
   function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
      return {1'b0, w[WIDTH-1:1]};
   endfunction
   function automatic logic [WIDTH-1:0] push_bit(input logic [WIDTH-1:0] w, input logic b);
      return {b, w[WIDTH-1:1]};
   endfunction
`else
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return w[WIDTH-1];
   endfunction
   function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
      return {w[WIDTH-2:0], 1'b0};
   endfunction
   function automatic logic [WIDTH-1:0] push_bit(input logic [WIDTH-1:0] w, input logic b);
      return {w[WIDTH-2:0], b};
   endfunction
`endif

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ssel_s = ssel_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign rise   = sck_s & ~sck_dly_q;
   assign fall   = ~sck_s & sck_dly_q;
   assign lead   = CPOL ? fall : rise;
   assign trail  = CPOL ? rise : fall;
   assign active = (state_q == SHIFT) && !ssel_s;

   // In CPHA=0 the trailing edge right after a word's last sample belongs to
   // the next word, whose first bit LOAD has already put on miso.
   assign sample_ev = active && (CPHA ? trail : lead);
   assign shift_ev  = active && (CPHA ? lead : (trail && cnt_q != '0));
   assign last_bit  = sample_ev && (cnt_q == CW'(WIDTH-1));

   // Edge detection on ssel_ waits until the chain holds real samples, so a
   // reset released mid-frame cannot fake a falling edge.
   assign ssel_fall = warm_q[SYNC_STAGES] && !ssel_s && ssel_dly_q;
   assign accept    = tx_valid && !hold_full_q;
   assign rx_next   = push_bit(rx_sh_q, mosi_s);

   always_comb begin
      state_d     = state_q;
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
      ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], ssel_};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_dly_d   = sck_s;
      ssel_dly_d  = ssel_s;
      warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};
      cnt_d       = cnt_q;
      rx_sh_d     = rx_sh_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      pend_d      = pend_q;
      tx_sh_d     = tx_sh_q;
      miso_bit_d  = miso_bit_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load_word   = '0;

      if (state_q != IDLE && ssel_s) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (ssel_fall) state_d = LOAD;
            LOAD: begin
               state_d = SHIFT;
               if (hold_full_q) begin
                  load_word   = hold_q;
                  hold_full_d = 1'b0;
               end
               pend_d = !hold_full_q;
               if (CPHA) begin
                  tx_sh_d = load_word;
               end else begin
                  miso_bit_d = first_bit(load_word);
                  tx_sh_d    = drop_bit(load_word);
               end
            end
            SHIFT: begin
               if (sample_ev) begin
                  rx_sh_d = rx_next;
                  cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
                  // Underrun is flagged once the empty word actually starts,
                  // not on the LOAD that follows a frame's final word.
                  if (cnt_q == '0 && pend_q) underrun_d = 1'b1;
                  if (last_bit) begin
                     rx_data_d  = rx_next;
                     rx_valid_d = 1'b1;
                     state_d    = LOAD;
                  end
               end
               if (shift_ev) begin
                  miso_bit_d = first_bit(tx_sh_q);
                  tx_sh_d    = drop_bit(tx_sh_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Accept is applied after the LOAD transfer so a same-cycle word is kept.
      if (accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sck_sync_q  <= {SYNC_STAGES{CPOL}};
         ssel_sync_q <= '1;
         mosi_sync_q <= '0;
         sck_dly_q   <= CPOL;
         ssel_dly_q  <= 1'b1;
         warm_q      <= '0;
         cnt_q       <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         pend_q      <= 1'b0;
         tx_sh_q     <= '0;
         miso_bit_q  <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         ssel_sync_q <= ssel_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_dly_q   <= sck_dly_d;
         ssel_dly_q  <= ssel_dly_d;
         warm_q      <= warm_d;
         cnt_q       <= cnt_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         pend_q      <= pend_d;
         tx_sh_q     <= tx_sh_d;
         miso_bit_q  <= miso_bit_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign miso        = (!ssel_ && state_q != IDLE) ? miso_bit_q : 1'bz;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = !hold_full_q;
   assign tx_underrun = underrun_q;
   assign led         = !ssel_s;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: instance 0 runs mode 0, instance 1 runs mode 3; rx words go through a scoreboard queue.
module tb_spi_slave_ctrl;
   localparam int W = 8;
   localparam int H = 6;

   logic clk = 1'b0;
   logic rst_;
   always #5 clk = ~clk;

   logic [1:0]   sck, ssel_, mosi, tx_valid;
   logic [W-1:0] tx_data [2];
   wire  [1:0]   miso;
   logic [W-1:0] rx_data [2];
   logic [1:0]   rx_valid, tx_ready, tx_underrun, led;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_slave_ctrl #(.WIDTH(W), .CPOL(g == 1), .CPHA(g == 1), .SYNC_STAGES(2)) u_dut (
         .clk(clk), .rst_(rst_), .sck(sck[g]), .ssel_(ssel_[g]), .mosi(mosi[g]),
         .miso(miso[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
         .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
         .tx_underrun(tx_underrun[g]), .led(led[g])
      );
   end

   int n_total = 0;
   int n_bad   = 0;
   int rxv_cnt [2];
   int und_cnt [2];
   int led_low [2];
   logic [W-1:0] rx_q0 [$];
   logic [W-1:0] rx_q1 [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] exp_w;
      if (rst_) begin
         for (int i = 0; i < 2; i++) begin
            if (tx_underrun[i]) und_cnt[i]++;
            if (rx_valid[i]) begin
               rxv_cnt[i]++;
               if ((i == 0 && rx_q0.size() == 0) || (i == 1 && rx_q1.size() == 0)) begin
                  chk("rx_unexpected", {31'b0, rx_valid[i]}, 32'd0);
               end else begin
                  if (i == 0) exp_w = rx_q0.pop_front();
                  else        exp_w = rx_q1.pop_front();
                  chk("rx_data", 32'(rx_data[i]), 32'(exp_w));
               end
            end
         end
      end
   end

   function automatic int pos(input int k);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return k;
`else
      return W - 1 - k;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic exp_rx(input int i, input logic [W-1:0] w);
      if (i == 0) rx_q0.push_back(w);
      else        rx_q1.push_back(w);
   endtask

   task automatic spi_begin(input int i);
      ssel_[i] = 1'b0;
      tick(8);
   endtask

   task automatic spi_end(input int i);
      tick(H);
      ssel_[i] = 1'b1;
      tick(8);
   endtask

   // Instance 0 is mode 0 (idle low, sample on rise); instance 1 is mode 3.
   task automatic spi_bit(input int i, input logic b, output logic r);
      if (i == 0) begin
         mosi[i] = b;
         tick(H);
         r = miso[i];
         if (!led[i]) led_low[i]++;
         sck[i] = 1'b1;
         tick(H);
         sck[i] = 1'b0;
      end else begin
         sck[i]  = 1'b0;
         mosi[i] = b;
         tick(H);
         r = miso[i];
         if (!led[i]) led_low[i]++;
         sck[i] = 1'b1;
         tick(H);
      end
   endtask

   task automatic spi_word(input int i, input logic [W-1:0] w, input int nbits, output logic [W-1:0] r);
      logic b;
      r = '0;
      for (int k = 0; k < nbits; k++) begin
         spi_bit(i, w[pos(k)], b);
         r[pos(k)] = b;
      end
   endtask

   task automatic tx_push(input int i, input logic [W-1:0] w);
      int n = 0;
      while (!tx_ready[i] && n < 400) begin
         tick(1);
         n++;
      end
      chk("tx_ready_wait", {31'b0, tx_ready[i]}, 32'd1);
      tx_data[i]  = w;
      tx_valid[i] = 1'b1;
      tick(1);
      tx_valid[i] = 1'b0;
      chk("tx_ready_after_accept", {31'b0, tx_ready[i]}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] r1, r2;
      int rv, un;
      rst_ = 1'b0;
      sck = 2'b10;
      ssel_ = 2'b11;
      mosi = 2'b00;
      tx_valid = 2'b00;
      tx_data[0] = '0;
      tx_data[1] = '0;
      for (int i = 0; i < 2; i++) begin
         rxv_cnt[i] = 0;
         und_cnt[i] = 0;
         led_low[i] = 0;
      end
      tick(3);
      for (int i = 0; i < 2; i++) begin
         chk("rst_rx_data",  32'(rx_data[i]), 32'd0);
         chk("rst_rx_valid", {31'b0, rx_valid[i]}, 32'd0);
         chk("rst_tx_ready", {31'b0, tx_ready[i]}, 32'd1);
         chk("rst_underrun", {31'b0, tx_underrun[i]}, 32'd0);
         chk("rst_led",      {31'b0, led[i]}, 32'd0);
      end
      rst_ = 1'b1;
      tick(10);

      // Mode 0, 0xC8 in, nothing to send: zeros out and a single underrun.
      rv = rxv_cnt[0]; un = und_cnt[0]; led_low[0] = 0;
      exp_rx(0, 8'hC8);
      spi_begin(0);
      spi_word(0, 8'hC8, W, r1);
      spi_end(0);
      chk("c8_rx_pulses", 32'(rxv_cnt[0] - rv), 32'd1);
      chk("c8_miso_word", 32'(r1), 32'h00);
      chk("c8_underrun",  32'(und_cnt[0] - un), 32'd1);
      chk("c8_led_low",   32'(led_low[0]), 32'd0);
      chk("c8_led_after", {31'b0, led[0]}, 32'd0);

      // Mode 3, 0xA5 staged before the frame.
      rv = rxv_cnt[1]; un = und_cnt[1];
      tx_push(1, 8'hA5);
      tick(5);
      chk("a5_ready_held", {31'b0, tx_ready[1]}, 32'd0);
      exp_rx(1, 8'h3C);
      spi_begin(1);
      spi_word(1, 8'h3C, W, r1);
      spi_end(1);
      chk("a5_miso_word", 32'(r1), 32'hA5);
      chk("a5_ready_back", {31'b0, tx_ready[1]}, 32'd1);
      chk("a5_underrun", 32'(und_cnt[1] - un), 32'd0);
      chk("a5_rx_pulses", 32'(rxv_cnt[1] - rv), 32'd1);

      // Mode 0, two back-to-back words; second tx word refilled mid-frame.
      rv = rxv_cnt[0]; un = und_cnt[0];
      tx_push(0, 8'h9E);
      exp_rx(0, 8'h12);
      exp_rx(0, 8'h34);
      spi_begin(0);
      fork
         begin
            spi_word(0, 8'h12, W, r1);
            spi_word(0, 8'h34, W, r2);
         end
         tx_push(0, 8'h67);
      join
      spi_end(0);
      chk("b2b_rx_pulses", 32'(rxv_cnt[0] - rv), 32'd2);
      chk("b2b_miso_w0", 32'(r1), 32'h9E);
      chk("b2b_miso_w1", 32'(r2), 32'h67);
      chk("b2b_underrun", 32'(und_cnt[0] - un), 32'd0);

      // Mode 0, frame aborted after 5 bits, then a clean 0x5A frame.
      rv = rxv_cnt[0];
      spi_begin(0);
      spi_word(0, 8'hFF, 5, r1);
      spi_end(0);
      chk("abort_rx_pulses", 32'(rxv_cnt[0] - rv), 32'd0);
      chk("abort_rx_hold", 32'(rx_data[0]), 32'h34);
      exp_rx(0, 8'h5A);
      spi_begin(0);
      spi_word(0, 8'h5A, W, r1);
      spi_end(0);
      chk("5a_rx_pulses", 32'(rxv_cnt[0] - rv), 32'd1);
      chk("5a_miso_word", 32'(r1), 32'h00);

      // Mode 3, reset mid-word with ssel_ held low across the release.
      rv = rxv_cnt[1];
      spi_begin(1);
      spi_word(1, 8'hF0, 4, r1);
      rst_ = 1'b0;
      tick(3);
      chk("midrst_rx_data", 32'(rx_data[1]), 32'd0);
      chk("midrst_ready",   {31'b0, tx_ready[1]}, 32'd1);
      chk("midrst_led",     {31'b0, led[1]}, 32'd0);
      rst_ = 1'b1;
      spi_word(1, 8'hF0, 4, r1);
      spi_end(1);
      chk("midrst_rx_pulses", 32'(rxv_cnt[1] - rv), 32'd0);
      exp_rx(1, 8'hE7);
      spi_begin(1);
      spi_word(1, 8'hE7, W, r1);
      spi_end(1);
      chk("fresh_rx_pulses", 32'(rxv_cnt[1] - rv), 32'd1);
      chk("fresh_rx_data", 32'(rx_data[1]), 32'hE7);
      chk("q_drained", 32'(rx_q0.size() + rx_q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
